wishbone_master: RTL and testbench

- Wishbone classic single-transfer initiator.
- Converts the CPU load/store unit's valid/ready request into one CYC/STB bus cycle and returns read data or an error.
- Sits between the core's memory stage and the data-side Wishbone bus, which carries the data RAM and peripherals.
- Provides alignment checking and a bus timeout, so a missing ACK never hangs the core.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_timeout_counter.sv | 32 +++
 rtl/wishbone_master.sv | 125 ++++++++++++
 tb/tb_wishbone_master.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone classic initiator: FSM encoding,
// full-word select constant and error causes.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } wb_state_e;

  localparam int unsigned WB_SEL_W = 4;
  localparam logic [WB_SEL_W-1:0] WB_SEL_ALL = '1;

  // Kept as a register in the master so a debug status register can expose it later.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BUS      = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_MISALIGN = 2'd3
  } wb_err_cause_e;

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts cycles spent waiting on the bus; flags the final allowed cycle.
// A TIMEOUT_CYCLES of 0 disables the timeout entirely.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam bit          ENABLED = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CNT_W-1:0] count;

  assign expired = ENABLED && enable && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (ENABLED && enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wishbone_master.sv
// Wishbone classic single-transfer initiator: turns one valid/ready CPU
// request into one CYC/STB cycle, with misalignment check and bus timeout.
module wishbone_master
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_sel,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                CYC_O,
  output logic                STB_O,
  output logic                WE_O,
  output logic [ADDR_W-1:0]   ADR_O,
  output logic [DATA_W-1:0]   DAT_O,
  output logic [DATA_W/8-1:0] SEL_O,
  input  logic [DATA_W-1:0]   DAT_I,
  input  logic                ACK_I,
  input  logic                ERR_I
);

  wb_state_e     state;
  wb_err_cause_e err_cause;
  logic          misaligned;
  logic          timed_out;
  logic          bus_end;

  // Only full-word accesses must be word aligned; narrower lane selects may sit anywhere.
  assign misaligned = (req_addr[1:0] != 2'b00) && (&req_sel);
  assign req_ready  = (state == IDLE);
  assign rsp_err    = (err_cause != ERR_NONE);
  assign bus_end    = (state == BUS) && (ACK_I || ERR_I || timed_out);

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .clear  ((state != BUS) || bus_end),
    .enable (state == BUS),
    .expired(timed_out)
  );

  // NOTE: every output flop is in the async reset so a reset mid-cycle drops CYC/STB without a clock.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state     <= IDLE;
      err_cause <= ERR_NONE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      CYC_O     <= 1'b0;
      STB_O     <= 1'b0;
      WE_O      <= 1'b0;
      ADR_O     <= '0;
      DAT_O     <= '0;
      SEL_O     <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          err_cause <= ERR_NONE;
          if (req_valid) begin
            if (misaligned) begin
              err_cause <= ERR_MISALIGN;
              rsp_valid <= 1'b1;
              state     <= DONE;
            end else begin
              CYC_O <= 1'b1;
              STB_O <= 1'b1;
              WE_O  <= req_we;
              ADR_O <= req_addr;
              DAT_O <= req_wdata;
              SEL_O <= req_sel;
              state <= BUS;
            end
          end
        end

        BUS: begin
          if (bus_end) begin
            if (ERR_I) begin
              err_cause <= ERR_BUS;
            end else if (ACK_I) begin
              err_cause <= ERR_NONE;
              if (!WE_O) begin
                rsp_rdata <= DAT_I;
              end
            end else begin
              err_cause <= ERR_TIMEOUT;
            end
            rsp_valid <= 1'b1;
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            WE_O      <= 1'b0;
            ADR_O     <= '0;
            DAT_O     <= '0;
            SEL_O     <= '0;
            state     <= DONE;
          end
        end

        DONE: begin
          rsp_valid <= 1'b0;
          err_cause <= ERR_NONE;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_master.sv
// Directed bench for wishbone_master with a response scoreboard and a
// simple programmable Wishbone slave.
module tb_wishbone_master;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_sel = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        CYC_O, STB_O, WE_O;
  logic [31:0] ADR_O, DAT_O;
  logic [3:0]  SEL_O;
  logic [31:0] DAT_I = '0;
  logic        ACK_I = 1'b0;
  logic        ERR_I = 1'b0;

  // second instance with the timeout disabled
  logic        nt_req_valid = 1'b0;
  logic        nt_req_ready, nt_rsp_valid, nt_rsp_err;
  logic [31:0] nt_rsp_rdata;
  logic        nt_cyc, nt_stb, nt_we;
  logic [31:0] nt_adr, nt_dat;
  logic [3:0]  nt_sel;

  always #5 CLK_I = ~CLK_I;

  wishbone_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O),
    .DAT_O(DAT_O), .SEL_O(SEL_O), .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I)
  );

  wishbone_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(0)) dut_nt (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .req_valid(nt_req_valid), .req_ready(nt_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(nt_rsp_valid), .rsp_rdata(nt_rsp_rdata), .rsp_err(nt_rsp_err),
    .CYC_O(nt_cyc), .STB_O(nt_stb), .WE_O(nt_we), .ADR_O(nt_adr),
    .DAT_O(nt_dat), .SEL_O(nt_sel), .DAT_I(32'h0), .ACK_I(1'b0), .ERR_I(1'b0)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // slave controls: mode 0 = ACK, 1 = ERR with ACK, 2 = never respond
  int          slave_wait = 0;
  int          slave_mode = 0;
  logic [31:0] slave_data = '0;

  // bus observation
  int          cyc_run = 0;
  int          cyc_last = 0;
  int          cyc_seen = 0;
  int          unstable = 0;
  logic        snap_we;
  logic [31:0] snap_adr, snap_dat;
  logic [3:0]  snap_sel;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // slave: drives ACK/ERR on the falling edge so they are sampled at the next rising edge
  initial begin
    int wcnt = 0;
    forever begin
      @(negedge CLK_I);
      if (CYC_O && STB_O) begin
        ACK_I = 1'b0;
        ERR_I = 1'b0;
        if (slave_mode != 2 && wcnt == slave_wait) begin
          ACK_I = 1'b1;
          ERR_I = (slave_mode == 1);
          DAT_I = slave_data;
        end
        wcnt++;
      end else begin
        wcnt  = 0;
        ACK_I = 1'b0;
        ERR_I = 1'b0;
      end
    end
  end

  // monitor: scoreboard pop on every response, plus bus-cycle length and stability tracking
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK_I);
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got rdata=%0h err=%0b expected no response", rsp_rdata, rsp_err);
        end else begin
          e = sb_q.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
        end
      end
      if (CYC_O) begin
        cyc_seen = 1;
        if (cyc_run == 0) begin
          snap_we  = WE_O;
          snap_adr = ADR_O;
          snap_dat = DAT_O;
          snap_sel = SEL_O;
        end else if (WE_O !== snap_we || ADR_O !== snap_adr || DAT_O !== snap_dat || SEL_O !== snap_sel) begin
          unstable++;
        end
        cyc_run++;
      end else if (cyc_run != 0) begin
        cyc_last = cyc_run;
        cyc_run  = 0;
      end
    end
  end

  task automatic xfer(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] sel,
                      input int wt, input int mode, input logic [31:0] sdata,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input int exp_cyc);
    int lat;
    slave_wait = wt;
    slave_mode = mode;
    slave_data = sdata;
    cyc_last   = 0;
    cyc_seen   = 0;
    unstable   = 0;
    sb_q.push_back(exp_t'{rdata: exp_rdata, err: exp_err});
    @(negedge CLK_I);
    check({name, "_ready_before"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_sel   = sel;
    @(posedge CLK_I);
    lat = 0;
    do begin
      @(negedge CLK_I);
      req_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 64);
    check({name, "_rsp_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy_at_rsp"}, 64'(req_ready), 64'd0);
    @(negedge CLK_I);
    check({name, "_ready_after"}, 64'(req_ready), 64'd1);
    check({name, "_cyc_len"}, 64'(cyc_last), 64'(exp_cyc));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge CLK_I);
    // reset state
    check("rst_cyc", 64'(CYC_O), 64'd0);
    check("rst_stb", 64'(STB_O), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_err", 64'(rsp_err), 64'd0);
    check("rst_adr", 64'(ADR_O), 64'd0);
    RST_I = 1'b1;
    @(negedge CLK_I);
    check("rst_ready", 64'(req_ready), 64'd1);

    // zero-wait load
    xfer("load0", 1'b0, 32'h10, 32'h0, 4'hF, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2, 1);

    // store with two wait states; read data must be left alone
    xfer("store2", 1'b1, 32'h20, 32'h12345678, 4'hF, 2, 0, 32'h0BADF00D, 32'hDEADBEEF, 1'b0, 4, 3);
    check("store_we", 64'(snap_we), 64'd1);
    check("store_adr", 64'(snap_adr), 64'h20);
    check("store_dat", 64'(snap_dat), 64'h12345678);
    check("store_sel", 64'(snap_sel), 64'hF);
    check("store_stable", 64'(unstable), 64'd0);
    check("idle_adr", 64'(ADR_O), 64'd0);
    check("idle_we", 64'(WE_O), 64'd0);

    // ERR_I wins over a simultaneous ACK_I
    xfer("errack", 1'b0, 32'h30, 32'h0, 4'hF, 0, 1, 32'hCAFEF00D, 32'hDEADBEEF, 1'b1, 2, 1);

    // silent slave: timeout after exactly 8 bus cycles
    xfer("timeout", 1'b0, 32'h40, 32'h0, 4'hF, 0, 2, 32'h11111111, 32'hDEADBEEF, 1'b1, 9, 8);

    // misaligned full-word load: no bus cycle at all
    xfer("misalign", 1'b0, 32'h13, 32'h0, 4'hF, 0, 0, 32'h22222222, 32'hDEADBEEF, 1'b1, 1, 0);
    check("misalign_no_cyc", 64'(cyc_seen), 64'd0);

    // single byte lane at an unaligned address is legal
    xfer("byte_unaligned", 1'b0, 32'h13, 32'h0, 4'h8, 0, 0, 32'h11223344, 32'h11223344, 1'b0, 2, 1);

    // reset two cycles into a bus wait
    slave_mode = 2;
    @(negedge CLK_I);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h50;
    req_sel   = 4'hF;
    @(posedge CLK_I);
    @(negedge CLK_I);
    req_valid = 1'b0;
    @(negedge CLK_I);
    check("pre_rst_cyc", 64'(CYC_O), 64'd1);
    #1 RST_I = 1'b0;
    #1;
    check("async_rst_cyc", 64'(CYC_O), 64'd0);
    check("async_rst_stb", 64'(STB_O), 64'd0);
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b1;
    @(negedge CLK_I);
    check("post_rst_ready", 64'(req_ready), 64'd1);
    check("post_rst_rdata", 64'(rsp_rdata), 64'd0);
    xfer("after_rst", 1'b0, 32'h60, 32'h0, 4'hF, 0, 0, 32'hA5A55A5A, 32'hA5A55A5A, 1'b0, 2, 1);

    // timeout disabled: the cycle stays open indefinitely
    @(negedge CLK_I);
    nt_req_valid = 1'b1;
    req_we   = 1'b0;
    req_addr = 32'h70;
    req_sel  = 4'hF;
    @(posedge CLK_I);
    @(negedge CLK_I);
    nt_req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 120; i++) begin
      if (nt_cyc && nt_stb) n++;
      @(negedge CLK_I);
    end
    check("no_timeout_cyc_len", 64'(n), 64'd120);
    check("no_timeout_no_rsp", 64'(nt_rsp_valid), 64'd0);

    repeat (2) @(negedge CLK_I);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
